sum_sched: RTL and testbench
============================

SUM_SCHED -- requirements
Module: sum_sched

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16); ID_W = $clog2(NUM_REQ).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port arst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_in1  in  NUM_REQ*BUS_WIDTH  operand A, requester i at slice [i*BUS_WIDTH +: BUS_WIDTH].
REQ-007 SHALL have port req_in2  in  NUM_REQ*BUS_WIDTH  operand B, same packing.
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot grant/accept pulse.
REQ-009 SHALL have port adder_in1, adder_in2  out  BUS_WIDTH each  operands to the shared adder.
REQ-010 SHALL have port adder_in_en  out  1  adder launch strobe.
REQ-011 SHALL have port adder_out, adder_carry, adder_out_en, adder_ready  in  BUS_WIDTH/1/1/1  adder result, carry, result-valid, adder-out-of-reset.
REQ-012 SHALL have port rsp_valid  out  1, rsp_ready  in  1, rsp_sum  out  BUS_WIDTH, rsp_carry  out  1, rsp_id  out  ID_W, rsp_err  out  1.
REQ-013 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-015 IDLE: when adder_ready=1 and any req_valid=1, SHALL assert req_ready for exactly one winner for one cycle, capture its operands and ID, go to ISSUE; otherwise stay, req_ready=0.
REQ-016 ISSUE: SHALL drive adder_in_en=1 for exactly one cycle with captured operands on adder_in1/2, go to WAIT; adder_in_en SHALL be 0 in all other states.
REQ-017 adder_in1/2 SHALL hold captured operands from ISSUE until the next accept.
REQ-018 WAIT: on adder_out_en=1 SHALL capture adder_out/adder_carry into rsp_sum/rsp_carry, go to RESP.
REQ-019 RESP: rsp_valid=1; rsp_sum/carry/id/err stable until rsp_valid&rsp_ready; then IDLE.
REQ-020 Latency: accept in cycle T -> adder_in_en in T+1 -> rsp_valid first high in T+3 (with 1-cycle adder); max throughput one op per 4 cycles.
REQ-021 adder_ready=0 while in ISSUE or WAIT SHALL abort to RESP with rsp_err=1, rsp_sum=0, rsp_carry=0, rsp_id=victim ID.
REQ-022 No arbitration SHALL occur outside IDLE; requests pending then SHALL be held off (req_ready=0), never dropped by the scheduler.
REQ-023 req_valid deasserted before grant SHALL be permitted; no state retained for it.
REQ-024 rsp_sum and rsp_carry SHALL be passed unmodified, widths exactly BUS_WIDTH and 1.

Reset
REQ-025 arst=0 SHALL asynchronously force: state IDLE, req_ready=0, adder_in_en=0, adder_in1/2=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, rsp_err=0, busy=0, RR pointer=NUM_REQ-1.
REQ-026 Reset mid-operation SHALL discard the in-flight operation; no response is produced after release.
REQ-027 First grant after reset release SHALL occur no earlier than the first rising edge with arst=1.

Configuration
REQ-028 Macro SUM_SCHED_RR_EN defined: round-robin; search starts at last-granted index+1 (mod NUM_REQ); pointer updates on each accept only.
REQ-029 SUM_SCHED_RR_EN undefined: fixed priority, lowest asserted index wins; no pointer state.

Verification
REQ-030 Single op: req_valid=4'b0001, in1=0x0000_0005, in2=0x0000_0003, rsp_ready=1 -> req_ready[0] at T, adder_in_en at T+1, rsp_valid at T+3 with sum=0x8, carry=0, id=0, err=0.
REQ-031 Carry: in1=0xFFFF_FFFF, in2=0x0000_0001 on requester 2 -> rsp_sum=0x0, rsp_carry=1, rsp_id=2.
REQ-032 Arbitration: req_valid=4'b1111 held, rsp_ready=1 -> with RR_EN grant order 0,1,2,3,0; without -> 0,0,0.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, no adder_in_en; accept resumes cycle after rsp_ready=1 handshake.
REQ-034 Abort: drop adder_ready during WAIT -> RESP with err=1, sum=0, id of granted requester; adder_ready=0 in IDLE -> no grants.
REQ-035 Reset mid-WAIT: arst=0 for 2 cycles -> all outputs zero immediately, no rsp_valid after release, next request served normally.

Source files
------------

// File: rtl/sum_sched.sv
// sum_sched: arbitrates NUM_REQ requesters onto one shared adder and returns
// each result through a valid/ready response channel.
//
// Ports:
//   clk, arst               clock, asynchronous active-low reset
//   req_valid/req_in1/2     per-requester request and packed operands
//   req_ready               one-hot accept pulse (combinational from state)
//   adder_in1/2, adder_in_en       operands and launch strobe to the adder
//   adder_out/carry/out_en/ready   adder result, carry, valid, alive flag
//   rsp_valid/ready, rsp_sum/carry/id/err   response channel
//   busy                    high whenever the FSM is not idle
//
// Configuration:
//   SUM_SCHED_RR_EN defined   -> round-robin arbitration with a grant pointer
//   SUM_SCHED_RR_EN undefined -> fixed priority, lowest index wins
module sum_sched #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned NUM_REQ   = 4,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_in2,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [BUS_WIDTH-1:0]         adder_in1,
  output logic [BUS_WIDTH-1:0]         adder_in2,
  output logic                         adder_in_en,
  input  logic [BUS_WIDTH-1:0]         adder_out,
  input  logic                         adder_carry,
  input  logic                         adder_out_en,
  input  logic                         adder_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BUS_WIDTH-1:0]         rsp_sum,
  output logic                         rsp_carry,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_err,
  output logic                         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic            found;
  logic            accept;

  // Unpack the operand buses into per-requester words
  logic [BUS_WIDTH-1:0] in1_arr [NUM_REQ];
  logic [BUS_WIDTH-1:0] in2_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign in1_arr[g] = req_in1[g*BUS_WIDTH +: BUS_WIDTH];
    assign in2_arr[g] = req_in2[g*BUS_WIDTH +: BUS_WIDTH];
  end

`ifdef SUM_SCHED_RR_EN
  // Round-robin: search starts one past the last granted index
  logic [ID_W-1:0] rr_ptr;
  int unsigned     idx;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + 32'd1 + i) % NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      rr_ptr <= win_id;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest asserted index
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[ID_W'(i)]) begin
        found  = 1'b1;
        win_id = ID_W'(i);
      end
    end
  end
`endif

  // Grant is decided in the IDLE cycle itself so the accept lands in the same
  // cycle as req_ready; gating with arst keeps it low while reset is held.
  assign accept    = (state == S_IDLE) && adder_ready && found;
  assign req_ready = (accept && arst) ? (NUM_REQ'(1) << win_id) : '0;

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state       <= S_IDLE;
      cur_id      <= '0;
      adder_in1   <= '0;
      adder_in2   <= '0;
      adder_in_en <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_sum     <= '0;
      rsp_carry   <= 1'b0;
      rsp_id      <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_ISSUE;
            cur_id      <= win_id;
            adder_in1   <= in1_arr[win_id];
            adder_in2   <= in2_arr[win_id];
            adder_in_en <= 1'b1;
            busy        <= 1'b1;
          end
        end

        S_ISSUE: begin
          adder_in_en <= 1'b0;
          if (!adder_ready) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= cur_id;
            rsp_err   <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Losing the adder wins over a coincident result
          if (!adder_ready) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= cur_id;
            rsp_err   <= 1'b1;
          end else if (adder_out_en) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_sum   <= adder_out;
            rsp_carry <= adder_carry;
            rsp_id    <= cur_id;
            rsp_err   <= 1'b0;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_sched.sv
module tb_sum_sched;

  localparam int unsigned BW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic                 clk = 1'b0;
  logic                 arst;
  logic [NR-1:0]        req_valid;
  logic [NR*BW-1:0]     req_in1;
  logic [NR*BW-1:0]     req_in2;
  logic [NR-1:0]        req_ready;
  logic [BW-1:0]        adder_in1;
  logic [BW-1:0]        adder_in2;
  logic                 adder_in_en;
  logic [BW-1:0]        adder_out;
  logic                 adder_carry;
  logic                 adder_out_en;
  logic                 adder_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BW-1:0]        rsp_sum;
  logic                 rsp_carry;
  logic [IW-1:0]        rsp_id;
  logic                 rsp_err;
  logic                 busy;
  logic                 adder_hold;

  int n_tests = 0;
  int n_fail  = 0;

  sum_sched #(.BUS_WIDTH(BW), .NUM_REQ(NR)) dut (
    .clk          (clk),
    .arst         (arst),
    .req_valid    (req_valid),
    .req_in1      (req_in1),
    .req_in2      (req_in2),
    .req_ready    (req_ready),
    .adder_in1    (adder_in1),
    .adder_in2    (adder_in2),
    .adder_in_en  (adder_in_en),
    .adder_out    (adder_out),
    .adder_carry  (adder_carry),
    .adder_out_en (adder_out_en),
    .adder_ready  (adder_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_sum      (rsp_sum),
    .rsp_carry    (rsp_carry),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // One-cycle adder; adder_hold makes it swallow a launch
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      adder_out_en <= 1'b0;
      adder_out    <= '0;
      adder_carry  <= 1'b0;
    end else begin
      adder_out_en              <= adder_in_en & ~adder_hold;
      {adder_carry, adder_out}  <= {1'b0, adder_in1} + {1'b0, adder_in2};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_in1[idx*BW +: BW] = a;
    req_in2[idx*BW +: BW] = b;
  endtask

  // Bounded wait for a response to appear
  task automatic wait_rsp(input string tag);
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) break;
      tick();
    end
    chk(tag, 32'(rsp_valid), 32'd1);
  endtask

  logic [NR-1:0] arb_exp [5];
  int            grants;
  int            last_c;

  initial begin
`ifdef SUM_SCHED_RR_EN
    arb_exp[0] = 4'b0001; arb_exp[1] = 4'b0010; arb_exp[2] = 4'b0100;
    arb_exp[3] = 4'b1000; arb_exp[4] = 4'b0001;
`else
    arb_exp[0] = 4'b0001; arb_exp[1] = 4'b0001; arb_exp[2] = 4'b0001;
    arb_exp[3] = 4'b0001; arb_exp[4] = 4'b0001;
`endif
    arst        = 1'b0;
    req_valid   = 4'b1111;
    req_in1     = '1;
    req_in2     = '1;
    rsp_ready   = 1'b1;
    adder_ready = 1'b1;
    adder_hold  = 1'b0;

    // Reset state, with requests pending
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_in_en", 32'(adder_in_en), 32'd0);
    chk("rst_in1", adder_in1, 32'd0);
    chk("rst_in2", adder_in2, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    arst = 1'b1;

    // Single op: 5 + 3 on requester 0, latency check
    set_op(0, 32'h5, 32'h3);
    req_valid = 4'b0001; #1;
    chk("op1_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; #1;
    chk("op1_ready_pulse", 32'(req_ready), 32'd0);
    chk("op1_in_en", 32'(adder_in_en), 32'd1);
    chk("op1_in1", adder_in1, 32'h5);
    chk("op1_in2", adder_in2, 32'h3);
    chk("op1_busy", 32'(busy), 32'd1);
    tick();
    chk("op1_in_en_off", 32'(adder_in_en), 32'd0);
    chk("op1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("op1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op1_sum", rsp_sum, 32'h8);
    chk("op1_carry", 32'(rsp_carry), 32'd0);
    chk("op1_id", 32'(rsp_id), 32'd0);
    chk("op1_err", 32'(rsp_err), 32'd0);
    tick();
    chk("op1_done", 32'(rsp_valid), 32'd0);
    chk("op1_idle", 32'(busy), 32'd0);
    chk("op1_in1_hold", adder_in1, 32'h5);

    // Carry out on requester 2
    set_op(2, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b0100; #1;
    chk("carry_grant", 32'(req_ready), 32'h4);
    tick(); req_valid = '0; #1;
    wait_rsp("carry_rsp_seen");
    chk("carry_sum", rsp_sum, 32'h0);
    chk("carry_carry", 32'(rsp_carry), 32'd1);
    chk("carry_id", 32'(rsp_id), 32'd2);
    chk("carry_err", 32'(rsp_err), 32'd0);
    tick();

    // Arbitration from a fresh pointer, all requesters held
    arst = 1'b0; #1;
    tick();
    arst = 1'b1;
    set_op(0, 32'h1, 32'h1); set_op(1, 32'h2, 32'h2);
    set_op(2, 32'h3, 32'h3); set_op(3, 32'h4, 32'h4);
    req_valid = 4'b1111; #1;
    grants = 0;
    last_c = 0;
    for (int c = 0; c < 40 && grants < 5; c++) begin
      if (req_ready != '0) begin
        chk($sformatf("arb_grant%0d", grants), 32'(req_ready), 32'(arb_exp[grants]));
        if (grants > 0) chk($sformatf("arb_gap%0d", grants), 32'(c - last_c), 32'd4);
        last_c = c;
        grants++;
      end
      tick();
    end
    chk("arb_count", 32'(grants), 32'd5);
    req_valid = '0; #1;
    for (int k = 0; k < 10; k++) begin
      if (!busy) break;
      tick();
    end
    chk("arb_drain", 32'(busy), 32'd0);

    // Backpressure: response held 5 cycles while requester 3 waits
    rsp_ready = 1'b0;
    set_op(1, 32'd10, 32'd20);
    set_op(3, 32'd40, 32'd2);
    req_valid = 4'b1010; #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = 4'b1000; #1;
    wait_rsp("bp_rsp_seen");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_sum%0d", k), rsp_sum, 32'd30);
      chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd1);
      chk($sformatf("bp_holdoff%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_no_launch%0d", k), 32'(adder_in_en), 32'd0);
      tick();
    end
    rsp_ready = 1'b1; #1;
    tick();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_resume_grant", 32'(req_ready), 32'h8);
    tick(); req_valid = '0; #1;
    wait_rsp("bp2_rsp_seen");
    chk("bp2_sum", rsp_sum, 32'd42);
    chk("bp2_id", 32'(rsp_id), 32'd3);
    tick();

    // Abort: adder drops out during WAIT
    adder_hold = 1'b1;
    set_op(0, 32'd7, 32'd8);
    req_valid = 4'b0001; #1;
    chk("ab_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; #1;
    tick();
    adder_ready = 1'b0; #1;
    tick();
    chk("ab_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ab_err", 32'(rsp_err), 32'd1);
    chk("ab_sum", rsp_sum, 32'd0);
    chk("ab_carry", 32'(rsp_carry), 32'd0);
    chk("ab_id", 32'(rsp_id), 32'd0);
    tick();
    req_valid = 4'b0001; #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ab_no_grant%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("ab_idle%0d", k), 32'(busy), 32'd0);
      tick();
    end
    adder_ready = 1'b1;
    adder_hold  = 1'b0; #1;
    chk("ab_recover_grant", 32'(req_ready), 32'h1);
    req_valid = '0; #1;

    // Reset while waiting on the adder
    adder_hold = 1'b1;
    set_op(2, 32'd1, 32'd1);
    req_valid = 4'b0100; #1;
    chk("mr_grant", 32'(req_ready), 32'h4);
    tick(); req_valid = '0; #1;
    tick();
    chk("mr_busy", 32'(busy), 32'd1);
    chk("mr_in1", adder_in1, 32'd1);
    arst = 1'b0; #1;
    chk("mr_in1_zero", adder_in1, 32'd0);
    chk("mr_in2_zero", adder_in2, 32'd0);
    chk("mr_busy_zero", 32'(busy), 32'd0);
    chk("mr_valid_zero", 32'(rsp_valid), 32'd0);
    chk("mr_in_en_zero", 32'(adder_in_en), 32'd0);
    tick(); tick();
    arst = 1'b1;
    adder_hold = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mr_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("mr_still_idle%0d", k), 32'(busy), 32'd0);
      tick();
    end
    set_op(1, 32'd100, 32'd200);
    req_valid = 4'b0010; #1;
    chk("mr_next_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; #1;
    wait_rsp("mr_next_rsp_seen");
    chk("mr_next_sum", rsp_sum, 32'd300);
    chk("mr_next_id", 32'(rsp_id), 32'd1);
    chk("mr_next_err", 32'(rsp_err), 32'd0);
    tick();
    chk("mr_next_done", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
